// File: rtl/cgra_io_sequencer.sv
// Host-side staging and control for the 4x3 torus PE array.
// Streams two lanes of input words into the array load ports for a programmed
// run length, drives the array enable, and captures the store ports into
// output buffers that the host reads back once the run has finished.
module cgra_io_sequencer #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 8,
  parameter int CWIDTH    = 16,
  parameter int STORE_LAT = 4
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              Host_Wr_En,
  input  logic              Host_Wr_Lane,
  input  logic [AWIDTH-1:0] Host_Wr_Addr,
  input  logic [DWIDTH-1:0] Host_Wr_Data,
  input  logic              Host_Rd_En,
  input  logic              Host_Rd_Lane,
  input  logic [AWIDTH-1:0] Host_Rd_Addr,
  output logic [DWIDTH-1:0] Host_Rd_Data,
  input  logic              Start,
  input  logic [CWIDTH-1:0] Cycle_Len,
  output logic              Seq_Busy,
  output logic              Done,
  output logic              PE_Array_Busy,
  output logic [DWIDTH-1:0] Data0_Load,
  output logic [DWIDTH-1:0] Data1_Load,
  input  logic [DWIDTH-1:0] Data0_Store,
  input  logic [DWIDTH-1:0] Data1_Store
);

  localparam int DEPTH  = 1 << AWIDTH;
  // Busy-cycle index reaches len + STORE_LAT - 1, one bit wider than the length.
  localparam int TWIDTH = CWIDTH + 1;
  localparam logic [TWIDTH-1:0] LAT_T = TWIDTH'(STORE_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [CWIDTH-1:0] r_len;   // latched run length
  logic [TWIDTH-1:0] r_t;     // elapsed busy-cycle index (equals k during RUN)
  logic [CWIDTH-1:0] r_s;     // number of store words captured so far

  logic [DWIDTH-1:0] r_ibuf0 [DEPTH];
  logic [DWIDTH-1:0] r_ibuf1 [DEPTH];
  logic [DWIDTH-1:0] r_obuf0 [DEPTH];
  logic [DWIDTH-1:0] r_obuf1 [DEPTH];

  logic [DWIDTH-1:0] r_load0;
  logic [DWIDTH-1:0] r_load1;
  logic [DWIDTH-1:0] r_ob0_q;
  logic [DWIDTH-1:0] r_ob1_q;
  logic              r_rd_zero;  // last read was issued while busy (or reset)
  logic              r_rd_lane;

  logic              w_idle;
  logic              w_in_busy;
  logic              w_run_last;
  logic              w_drain_last;
  logic              w_capture;
  logic [TWIDTH-1:0] w_len_t;
  logic [AWIDTH-1:0] w_pf_addr;
  logic [AWIDTH-1:0] w_st_addr;

  assign w_idle       = (r_state == S_IDLE);
  assign w_in_busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_len_t      = TWIDTH'(r_len);
  assign w_run_last   = (r_t == w_len_t - TWIDTH'(1));
  assign w_drain_last = (r_t == w_len_t + LAT_T - TWIDTH'(1));
  assign w_capture    = w_in_busy && (r_t >= LAT_T) && (r_s < r_len);
  // Address of the word presented in the next RUN cycle: 0 when launching
  // from IDLE (prefetch), k+1 while running. Wraps modulo DEPTH.
  assign w_pf_addr    = w_idle ? '0 : AWIDTH'(r_t + TWIDTH'(1));
  assign w_st_addr    = AWIDTH'(r_s);

  // State register.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves w_next
    // unassigned and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next = (Cycle_Len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_run_last) w_next = (STORE_LAT > 0) ? S_DRAIN : S_DONE;
      S_DRAIN: if (w_drain_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    PE_Array_Busy = w_in_busy;
    Seq_Busy      = !w_idle;
    Done          = (r_state == S_DONE);
  end

  // Run length, busy-cycle index and store counter.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      r_len <= '0;
      r_t   <= '0;
      r_s   <= '0;
    end else if (w_idle && Start) begin
      r_len <= Cycle_Len;
      r_t   <= '0;
      r_s   <= '0;
    end else if (w_in_busy) begin
      r_t <= r_t + TWIDTH'(1);
      if (w_capture) r_s <= r_s + CWIDTH'(1);
    end
  end

  // Input buffers: host writes accepted only while the sequencer is idle.
  always_ff @(posedge Clk) begin
    // NOTE: buffer RAMs carry no reset so they map onto block RAM; their
    // contents survive Resetn by design.
    if (Host_Wr_En && w_idle) begin
      if (Host_Wr_Lane) r_ibuf1[Host_Wr_Addr] <= Host_Wr_Data;
      else              r_ibuf0[Host_Wr_Addr] <= Host_Wr_Data;
    end
  end

  // Synchronous read of both input lanes into the load-port registers.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      r_load0 <= '0;
      r_load1 <= '0;
    end else if (w_next == S_RUN) begin
      r_load0 <= r_ibuf0[w_pf_addr];
      r_load1 <= r_ibuf1[w_pf_addr];
    end else begin
      r_load0 <= '0;
      r_load1 <= '0;
    end
  end

  assign Data0_Load = r_load0;
  assign Data1_Load = r_load1;

  // Store-port capture into the output buffers once results start arriving.
  always_ff @(posedge Clk) begin
    if (Resetn && w_capture) begin
      r_obuf0[w_st_addr] <= Data0_Store;
      r_obuf1[w_st_addr] <= Data1_Store;
    end
  end

  // Output buffer synchronous read ports.
  always_ff @(posedge Clk) begin
    if (Host_Rd_En) begin
      r_ob0_q <= r_obuf0[Host_Rd_Addr];
      r_ob1_q <= r_obuf1[Host_Rd_Addr];
    end
  end

  // Read qualifiers: lane select and the busy mask, aligned with the RAM data.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      r_rd_zero <= 1'b1;
      r_rd_lane <= 1'b0;
    end else if (Host_Rd_En) begin
      r_rd_zero <= !w_idle;
      r_rd_lane <= Host_Rd_Lane;
    end
  end

  assign Host_Rd_Data = r_rd_zero ? '0 : (r_rd_lane ? r_ob1_q : r_ob0_q);

endmodule

// File: tb/tb_cgra_io_sequencer.sv
// Self-checking bench for cgra_io_sequencer. Instance u_dut uses default
// parameters with an array model that returns load+0x100 four cycles later;
// instance u_dut_w uses AWIDTH=2, STORE_LAT=0 with a zero-latency array model
// whose result also encodes the busy-cycle index, so address wrap is visible.
module tb_cgra_io_sequencer;

  localparam int A_LAT = 4;

  logic        Clk = 1'b0;
  logic        Resetn;

  logic        wr_en, wr_lane, rd_en, rd_lane, start;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data, load0, load1, store0, store1;
  logic [15:0] cycle_len;
  logic        seq_busy, done, pe_busy;

  logic        b_wr_en, b_wr_lane, b_rd_en, b_rd_lane, b_start;
  logic [1:0]  b_wr_addr, b_rd_addr;
  logic [31:0] b_wr_data, b_rd_data, b_load0, b_load1, b_store0, b_store1;
  logic [15:0] b_cycle_len;
  logic        b_seq_busy, b_done, b_pe_busy;

  logic [31:0] pipe0 [A_LAT];
  logic [31:0] pipe1 [A_LAT];
  logic [7:0]  b_cyc;

  logic [31:0] exp0_q [$];
  logic [31:0] exp1_q [$];
  logic [31:0] rd_q   [$];

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  cgra_io_sequencer u_dut (
    .Clk(Clk), .Resetn(Resetn),
    .Host_Wr_En(wr_en), .Host_Wr_Lane(wr_lane), .Host_Wr_Addr(wr_addr), .Host_Wr_Data(wr_data),
    .Host_Rd_En(rd_en), .Host_Rd_Lane(rd_lane), .Host_Rd_Addr(rd_addr), .Host_Rd_Data(rd_data),
    .Start(start), .Cycle_Len(cycle_len), .Seq_Busy(seq_busy), .Done(done),
    .PE_Array_Busy(pe_busy), .Data0_Load(load0), .Data1_Load(load1),
    .Data0_Store(store0), .Data1_Store(store1)
  );

  cgra_io_sequencer #(.AWIDTH(2), .STORE_LAT(0)) u_dut_w (
    .Clk(Clk), .Resetn(Resetn),
    .Host_Wr_En(b_wr_en), .Host_Wr_Lane(b_wr_lane), .Host_Wr_Addr(b_wr_addr), .Host_Wr_Data(b_wr_data),
    .Host_Rd_En(b_rd_en), .Host_Rd_Lane(b_rd_lane), .Host_Rd_Addr(b_rd_addr), .Host_Rd_Data(b_rd_data),
    .Start(b_start), .Cycle_Len(b_cycle_len), .Seq_Busy(b_seq_busy), .Done(b_done),
    .PE_Array_Busy(b_pe_busy), .Data0_Load(b_load0), .Data1_Load(b_load1),
    .Data0_Store(b_store0), .Data1_Store(b_store1)
  );

  // Array model for u_dut: store = load + 0x100, delayed A_LAT cycles.
  always @(posedge Clk) begin
    pipe0[0] <= load0 + 32'h100;
    pipe1[0] <= load1 + 32'h100;
    for (int i = 1; i < A_LAT; i++) begin
      pipe0[i] <= pipe0[i-1];
      pipe1[i] <= pipe1[i-1];
    end
  end
  assign store0 = pipe0[A_LAT-1];
  assign store1 = pipe1[A_LAT-1];

  // Array model for u_dut_w: store = load + busy_index*0x100, same cycle.
  always @(posedge Clk) begin
    if (!Resetn || (b_start && !b_seq_busy)) b_cyc <= 8'd0;
    else if (b_pe_busy)                     b_cyc <= b_cyc + 8'd1;
  end
  assign b_store0 = b_load0 + ({24'h0, b_cyc} << 8);
  assign b_store1 = b_load1 + ({24'h0, b_cyc} << 8);

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic write_a(input logic lane, input logic [7:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_lane = lane; wr_addr = addr; wr_data = data;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic write_b(input logic lane, input logic [1:0] addr, input logic [31:0] data);
    b_wr_en = 1'b1; b_wr_lane = lane; b_wr_addr = addr; b_wr_data = data;
    tick;
    b_wr_en = 1'b0;
  endtask

  // Read obuf[lane][0..3] of u_dut and expect base+i, one cycle after each strobe.
  task automatic readback_a(input logic lane, input logic [31:0] base, input string tag);
    logic [31:0] want;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_lane = lane; rd_addr = 8'(i);
      rd_q.push_back(base + 32'(i));
      tick;
      rd_en = 1'b0;
      want = rd_q.pop_front();
      checks++;
      if (rd_data !== want) begin
        errors++;
        $display("FAIL %s[%0d]: got %h want %h", tag, i, rd_data, want);
      end
    end
  endtask

  // Launch a run on u_dut and follow it to Done. At busy-relative cycle
  // 'poke' a second Start and a host write to ibuf0[1] are driven.
  task automatic run_a(input int len, input int poke, input string tag);
    int busy_n;
    int done_at;
    logic [31:0] w0, w1;
    busy_n = 0; done_at = -1;
    cycle_len = 16'(len); start = 1'b1;
    tick;
    start = 1'b0;
    for (int cyc = 0; cyc < len + A_LAT + 8; cyc++) begin
      start   = (cyc == poke);
      wr_en   = (cyc == poke);
      wr_lane = 1'b0; wr_addr = 8'd1; wr_data = 32'hdead_beef;
      if (pe_busy) begin
        checks++;
        if (busy_n < len) begin
          if (exp0_q.size() == 0 || exp1_q.size() == 0) begin
            errors++;
            $display("FAIL %s_load: scoreboard empty at busy cycle %0d", tag, busy_n);
          end else begin
            w0 = exp0_q.pop_front(); w1 = exp1_q.pop_front();
            if (load0 !== w0 || load1 !== w1) begin
              errors++;
              $display("FAIL %s_load[%0d]: got %h/%h want %h/%h", tag, busy_n, load0, load1, w0, w1);
            end
          end
        end else if (load0 !== 32'h0 || load1 !== 32'h0) begin
          errors++;
          $display("FAIL %s_drain_load[%0d]: got %h/%h want 0/0", tag, busy_n, load0, load1);
        end
        busy_n++;
      end else if (done) begin
        done_at = cyc;
        break;
      end
      tick;
    end
    start = 1'b0; wr_en = 1'b0;
    checks++;
    if (busy_n != len + A_LAT) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d want %0d", tag, busy_n, len + A_LAT);
    end
    checks++;
    if (done_at != len + A_LAT) begin
      errors++;
      $display("FAIL %s_done_at: got %0d want %0d", tag, done_at, len + A_LAT);
    end
    checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_left: got %0d/%0d words left want 0/0", tag, exp0_q.size(), exp1_q.size());
      exp0_q.delete(); exp1_q.delete();
    end
    tick;
    checks++;
    if (done !== 1'b0 || seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after: got done=%b seq_busy=%b want 0/0", tag, done, seq_busy);
    end
    tick;
    checks++;
    if (seq_busy !== 1'b0 || pe_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_no_requeue: got seq_busy=%b pe_busy=%b want 0/0", tag, seq_busy, pe_busy);
    end
  endtask

  task automatic test_reset;
    Resetn = 1'b0; start = 1'b1; cycle_len = 16'd4; b_start = 1'b1; b_cycle_len = 16'd4;
    repeat (3) tick;
    checks++;
    if (pe_busy !== 1'b0 || done !== 1'b0 || seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got pe_busy=%b done=%b seq_busy=%b want 0", pe_busy, done, seq_busy);
    end
    checks++;
    if (load0 !== 32'h0 || load1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_loads: got %h/%h want 0/0", load0, load1);
    end
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h want 0", rd_data);
    end
    checks++;
    if (b_pe_busy !== 1'b0 || b_done !== 1'b0 || b_load0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_w: got pe_busy=%b done=%b load0=%h want 0", b_pe_busy, b_done, b_load0);
    end
    Resetn = 1'b1; start = 1'b0; b_start = 1'b0;
    tick; tick;
    checks++;
    if (seq_busy !== 1'b0 || pe_busy !== 1'b0 || b_seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_stays_idle: got seq_busy=%b pe_busy=%b w_seq_busy=%b want 0", seq_busy, pe_busy, b_seq_busy);
    end
  endtask

  task automatic test_basic_run;
    for (int i = 0; i < 4; i++) begin
      write_a(1'b0, 8'(i), 32'h10 + 32'(i));
      write_a(1'b1, 8'(i), 32'h20 + 32'(i));
      exp0_q.push_back(32'h10 + 32'(i));
      exp1_q.push_back(32'h20 + 32'(i));
    end
    run_a(4, -1, "basic");
    readback_a(1'b0, 32'h110, "basic_obuf0");
    readback_a(1'b1, 32'h120, "basic_obuf1");
  endtask

  task automatic test_zero_len;
    cycle_len = 16'd0; start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || pe_busy !== 1'b0 || seq_busy !== 1'b1) begin
      errors++;
      $display("FAIL zl_done_cycle: got done=%b pe_busy=%b seq_busy=%b want 1/0/1", done, pe_busy, seq_busy);
    end
    rd_en = 1'b1; rd_lane = 1'b0; rd_addr = 8'd0;
    rd_q.push_back(32'h0);
    tick;
    rd_en = 1'b0;
    checks++;
    if (rd_data !== rd_q[0]) begin
      errors++;
      $display("FAIL zl_busy_read: got %h want %h", rd_data, rd_q[0]);
    end
    void'(rd_q.pop_front());
    checks++;
    if (done !== 1'b0 || pe_busy !== 1'b0 || seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL zl_after: got done=%b pe_busy=%b seq_busy=%b want 0", done, pe_busy, seq_busy);
    end
    readback_a(1'b0, 32'h110, "zl_obuf0");
  endtask

  task automatic test_busy_ignored;
    for (int i = 0; i < 4; i++) begin
      write_a(1'b0, 8'(i), 32'h30 + 32'(i));
      write_a(1'b1, 8'(i), 32'h40 + 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      exp0_q.push_back(32'h30 + 32'(i));
      exp1_q.push_back(32'h40 + 32'(i));
    end
    run_a(4, 1, "poke");
    readback_a(1'b0, 32'h130, "poke_obuf0");
    // Second run shows ibuf0[1] kept its original word.
    for (int i = 0; i < 4; i++) begin
      exp0_q.push_back(32'h30 + 32'(i));
      exp1_q.push_back(32'h40 + 32'(i));
    end
    run_a(4, -1, "recheck");
  endtask

  task automatic test_wrap;
    int busy_n;
    int done_at;
    logic [31:0] w0, w1;
    logic [31:0] m0 [4];
    logic [31:0] m1 [4];
    for (int i = 0; i < 4; i++) begin
      write_b(1'b0, 2'(i), 32'h50 + 32'(i));
      write_b(1'b1, 2'(i), 32'h60 + 32'(i));
    end
    for (int t = 0; t < 6; t++) begin
      exp0_q.push_back(32'h50 + 32'(t % 4));
      exp1_q.push_back(32'h60 + 32'(t % 4));
      m0[t % 4] = 32'h50 + 32'(t % 4) + 32'(t * 256);
      m1[t % 4] = 32'h60 + 32'(t % 4) + 32'(t * 256);
    end
    busy_n = 0; done_at = -1;
    b_cycle_len = 16'd6; b_start = 1'b1;
    tick;
    b_start = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (b_pe_busy) begin
        checks++;
        if (exp0_q.size() == 0 || exp1_q.size() == 0) begin
          errors++;
          $display("FAIL wrap_load: scoreboard empty at busy cycle %0d", busy_n);
        end else begin
          w0 = exp0_q.pop_front(); w1 = exp1_q.pop_front();
          if (b_load0 !== w0 || b_load1 !== w1) begin
            errors++;
            $display("FAIL wrap_load[%0d]: got %h/%h want %h/%h", busy_n, b_load0, b_load1, w0, w1);
          end
        end
        busy_n++;
      end else if (b_done) begin
        done_at = cyc;
        break;
      end
      tick;
    end
    checks++;
    if (busy_n != 6 || done_at != 6) begin
      errors++;
      $display("FAIL wrap_timing: got busy=%0d done_at=%0d want 6/6", busy_n, done_at);
    end
    exp0_q.delete(); exp1_q.delete();
    tick;
    checks++;
    if (b_seq_busy !== 1'b0 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle: got seq_busy=%b done=%b want 0/0", b_seq_busy, b_done);
    end
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 4; i++) begin
        b_rd_en = 1'b1; b_rd_lane = l[0]; b_rd_addr = 2'(i);
        rd_q.push_back((l == 0) ? m0[i] : m1[i]);
        tick;
        b_rd_en = 1'b0;
        w0 = rd_q.pop_front();
        checks++;
        if (b_rd_data !== w0) begin
          errors++;
          $display("FAIL wrap_obuf%0d[%0d]: got %h want %h", l, i, b_rd_data, w0);
        end
      end
    end
  endtask

  task automatic test_reset_in_drain;
    cycle_len = 16'd4; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    checks++;
    if (pe_busy !== 1'b1 || load0 !== 32'h0) begin
      errors++;
      $display("FAIL rd_in_drain: got pe_busy=%b load0=%h want 1/0", pe_busy, load0);
    end
    Resetn = 1'b0;
    tick;
    checks++;
    if (pe_busy !== 1'b0 || done !== 1'b0 || seq_busy !== 1'b0 || load0 !== 32'h0 || load1 !== 32'h0 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL rd_abort: got pe_busy=%b done=%b seq_busy=%b loads=%h/%h rd=%h want all 0",
               pe_busy, done, seq_busy, load0, load1, rd_data);
    end
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (done !== 1'b0 || seq_busy !== 1'b0) begin
        errors++;
        $display("FAIL rd_no_done[%0d]: got done=%b seq_busy=%b want 0/0", i, done, seq_busy);
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp0_q.push_back(32'h30 + 32'(i));
      exp1_q.push_back(32'h40 + 32'(i));
    end
    run_a(4, -1, "post_reset");
    readback_a(1'b0, 32'h130, "post_reset_obuf0");
    readback_a(1'b1, 32'h140, "post_reset_obuf1");
  endtask

  initial begin
    Resetn = 1'b0;
    wr_en = 1'b0; wr_lane = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_lane = 1'b0; rd_addr = '0; start = 1'b0; cycle_len = '0;
    b_wr_en = 1'b0; b_wr_lane = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_rd_en = 1'b0; b_rd_lane = 1'b0; b_rd_addr = '0; b_start = 1'b0; b_cycle_len = '0;
    test_reset;
    test_basic_run;
    test_zero_len;
    test_busy_ignored;
    test_wrap;
    test_reset_in_drain;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
